systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Upstream stage of the systolic processing-element array. Accepts weight rows and activation vectors over valid/ready handshakes, sequences the array's weight-load phase, then streams activations into the array's left edge with per-row diagonal skew: row r is delayed r cycles. Idle and bubble slots are driven as zero with valid low, so every element's running sum stays clean.

## Interface
- DATA_WIDTH, 4, signed element width; matches the PE element width.
- ARRAY_SIZE, 4, number of array rows and columns (N).
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  one-cycle pulse; begins a job when IDLE.
- w_valid  input  1  weight row available.
- w_ready  output  1  weight row accepted when high with w_valid.
- w_data  input  N*DATA_WIDTH  weight row; element c at bits [c*DW +: DW].
- in_valid  input  1  activation vector available.
- in_ready  output  1  activation vector accepted when high with in_valid.
- in_data  input  N*DATA_WIDTH  activation vector; element r goes to array row r.
- in_last  input  1  marks the final vector of the job; qualified by handshake.
- pe_load  output  1  weight-load strobe to the array.
- pe_weight  output  N*DATA_WIDTH  weight row to the array's top edge.
- pe_val  output  N*DATA_WIDTH  skewed activations to the array's left edge.
- pe_valid  output  N  per-row valid of pe_val.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at job end.

## Operation
FSM states: IDLE, LOAD_W, STREAM, DRAIN.
- IDLE: all handshakes deasserted. `start` moves to LOAD_W and clears the row counter.
- LOAD_W:
  - w_ready=1.
  - On each handshake, register w_data onto pe_weight with pe_load=1 for exactly one cycle.
  - Upstream supplies the bottom array row first.
  - After the N-th accepted row, go to STREAM.
  - pe_load=0 and pe_weight holds its last value on non-handshake cycles.
- STREAM:
  - in_ready=1.
  - An accepted vector enters skew lane r at stage 0 with valid=1.
  - A non-accept cycle inserts 0 with valid=0 (bubble).
  - An accepted in_last moves to DRAIN.
- DRAIN:
  - in_ready=0; zeros with valid=0 are inserted.
  - Lasts N-1 cycles, then one cycle with done=1, then IDLE.
  - When N=1, DRAIN lasts 0 cycles, so done is asserted the cycle after the in_last handshake.
- Skew lanes are shift registers of depth r+1 for row r. They shift every cycle in every state.
- Values are passed bit-exact (signed, no arithmetic).
- `start` while busy is ignored.
- w_valid in any state other than LOAD_W, and in_valid in any state other than STREAM, are ignored (ready low).

## Timing
- Reset values: pe_load=0, pe_weight=0, pe_val=0, pe_valid=0, w_ready=0, in_ready=0, busy=0, done=0; state IDLE. All skew stages are zero.
- start at cycle t: busy=1 and w_ready=1 from t+1.
- Weight handshake at cycle t: pe_load=1 and pe_weight valid at t+1.
- Activation handshake at cycle t: row r value on pe_val at t+1+r, with pe_valid[r]=1.
- in_last handshake at cycle t:
  - last row-(N-1) element appears at t+N.
  - done=1 at t+N; busy drops at t+N+1.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. There is no partial-job recovery.
- ready signals are registered from state; they do not depend combinationally on valid.

## Configuration
- FEEDER_STATS_EN defined: adds output `vec_count` [15:0].
  - Cleared on start.
  - Increments on each accepted activation vector.
  - Saturates at 16'hFFFF.
  - Holds its value after done.
  - Reset value 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- The shared package holds:
  - the FSM state typedef (IDLE, LOAD_W, STREAM, DRAIN);
  - the default DATA_WIDTH and ARRAY_SIZE constants;
  - a localparam helper for counter width, $clog2(ARRAY_SIZE+1).
- One sub-module, `skew_lane`, is parameterised by DEPTH and DATA_WIDTH. It is a shift register carrying value+valid, with asynchronous reset to zero. It is instantiated N times in a generate loop with DEPTH=r+1.

## Test plan
- Reset check: assert reset mid-STREAM with in_data=16'h7F31 → all outputs 0 next edge; state IDLE; no done pulse.
- Weight load (N=4, DW=4): start, then rows 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0 back-to-back → four pe_load pulses carrying the same values in order; STREAM entered after the 4th.
- Skew:
  - stimulus: single vector 16'h4321 with in_last, accepted at cycle t;
  - pe_val row 0 = 1 at t+1, row 1 = 2 at t+2, row 2 = 3 at t+3, row 3 = 4 at t+4;
  - done at t+4.
- Bubble:
  - stimulus: vectors 16'h1111, gap cycle, 16'h2222 (last);
  - each lane shows 1, 0 with valid=0, then 2, each offset by its row index.
- Negative values: vector 16'h8F0F → row 0 = -1, row 1 = 0, row 2 = -1, row 3 = -8, each arriving bit-exact.
- Ignored inputs:
  - start pulsed during STREAM → no effect;
  - w_valid during STREAM → w_ready stays 0;
  - with FEEDER_STATS_EN, vec_count=2 after the bubble test.

Source files
------------

// File: rtl/systolic_feeder_pkg.sv
// Shared types and constants for the systolic array feeder.
package systolic_feeder_pkg;

    // Feeder sequencing phases.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH = 4;
    localparam int unsigned DEFAULT_ARRAY_SIZE = 4;

    // Width of a counter that must hold values 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned DEFAULT_CNT_WIDTH = $clog2(DEFAULT_ARRAY_SIZE + 1);

endpackage

// File: rtl/systolic_feeder_skew_lane.sv
// skew_lane: fixed-depth shift register carrying a value and its valid flag.
// Shifts every cycle; the output is the value presented DEPTH cycles earlier.
module skew_lane
    import systolic_feeder_pkg::*;
#(
    parameter int unsigned DEPTH      = 1,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_val,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_val,
    output logic                  out_valid
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] val_q;
    logic [DEPTH-1:0]                 valid_q;

    // Shift value and valid one stage per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_q   <= '0;
            valid_q <= '0;
        end else begin
            val_q[0]   <= in_val;
            valid_q[0] <= in_valid;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                val_q[i]   <= val_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign out_val   = val_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: loads N weight rows into the PE array, then streams
// activation vectors into its left edge with row r delayed by r cycles.
// Optional build macro FEEDER_STATS_EN adds the vec_count output, a
// saturating count of accepted activation vectors for the current job.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ARRAY_SIZE = DEFAULT_ARRAY_SIZE
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             w_valid,
    output logic                             w_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_data,
    input  logic                             in_last,
    output logic                             pe_load,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] pe_weight,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] pe_val,
    output logic [ARRAY_SIZE-1:0]            pe_valid,
    output logic                             busy,
    output logic                             done
`ifdef FEEDER_STATS_EN
    ,
    output logic [15:0]                      vec_count
`endif
);

    localparam int unsigned CNT_W = cnt_width(ARRAY_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ARRAY_SIZE - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             w_accept_c;
    logic             in_accept_c;

    assign cnt_inc_c   = cnt + CNT_W'(1);
    assign w_accept_c  = w_valid & w_ready;
    assign in_accept_c = in_valid & in_ready;

    // Job sequencer: weight load, stream, drain; cnt counts rows then drain cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            w_ready   <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pe_load   <= 1'b0;
            pe_weight <= '0;
        end else begin
            pe_load <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD_W;
                        cnt     <= '0;
                        w_ready <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                LOAD_W: begin
                    if (w_accept_c) begin
                        pe_weight <= w_data;
                        pe_load   <= 1'b1;
                        if (cnt == CNT_LAST) begin
                            state    <= STREAM;
                            w_ready  <= 1'b0;
                            in_ready <= 1'b1;
                        end else begin
                            cnt <= cnt_inc_c;
                        end
                    end
                end
                STREAM: begin
                    if (in_accept_c && in_last) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                        cnt      <= '0;
                        done     <= (CNT_LAST == '0);
                    end
                end
                DRAIN: begin
                    // Last DRAIN cycle is the one presenting done.
                    if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt  <= cnt_inc_c;
                        done <= (cnt_inc_c == CNT_LAST);
                    end
                end
                default: begin
                    state    <= IDLE;
                    w_ready  <= 1'b0;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // One skew lane per array row; row r is delayed r+1 register stages.
    for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_lane
        logic [DATA_WIDTH-1:0] lane_in_c;

        assign lane_in_c = in_accept_c ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;

        skew_lane #(
            .DEPTH      (r + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .in_val    (lane_in_c),
            .in_valid  (in_accept_c),
            .out_val   (pe_val[r*DATA_WIDTH +: DATA_WIDTH]),
            .out_valid (pe_valid[r])
        );
    end

`ifdef FEEDER_STATS_EN
    // Saturating count of accepted activation vectors, cleared on job start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_count <= '0;
        end else if (state == IDLE && start) begin
            vec_count <= '0;
        end else if (in_accept_c && vec_count != 16'hFFFF) begin
            vec_count <= vec_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: drivers push expected responses,
// a negedge monitor pops and compares them cycle by cycle.
module tb_systolic_feeder;
    import systolic_feeder_pkg::*;

    localparam int unsigned DW  = DEFAULT_DATA_WIDTH;
    localparam int unsigned N   = DEFAULT_ARRAY_SIZE;
    localparam int unsigned VW  = N * DW;
    localparam int          BIG = 32'h3FFF_FFFF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          w_valid = 1'b0;
    logic [VW-1:0] w_data = '0;
    logic          in_valid = 1'b0;
    logic [VW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          w_ready, in_ready, pe_load, busy, done;
    logic [VW-1:0] pe_weight, pe_val;
    logic [N-1:0]  pe_valid;
`ifdef FEEDER_STATS_EN
    logic [15:0]   vec_count;
`endif

    systolic_feeder #(.DATA_WIDTH(DW), .ARRAY_SIZE(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .pe_load   (pe_load),
        .pe_weight (pe_weight),
        .pe_val    (pe_val),
        .pe_valid  (pe_valid),
        .busy      (busy),
        .done      (done)
`ifdef FEEDER_STATS_EN
        ,
        .vec_count (vec_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [DW-1:0] val; } lane_exp_t;
    typedef struct { int cyc; logic [VW-1:0] data; } w_exp_t;

    // Reference model: what each output must show, and when.
    lane_exp_t     lane_q [N][$];
    w_exp_t        w_q[$];
    int            done_q[$];
    logic [VW-1:0] last_w = '0;
    int            busy_from = BIG;
    int            busy_until = BIG;
    int            vec_model = 0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic reset_model();
        for (int r = 0; r < int'(N); r++) lane_q[r].delete();
        w_q.delete();
        done_q.delete();
        last_w     = '0;
        busy_from  = BIG;
        busy_until = BIG;
        vec_model  = 0;
    endtask

    // Monitor: compare every output against the scoreboard each cycle.
    always @(negedge clk) begin
        logic          ev;
        logic [DW-1:0] ed;
        logic          wl;
        for (int r = 0; r < int'(N); r++) begin
            ev = 1'b0;
            ed = '0;
            if (lane_q[r].size() > 0 && lane_q[r][0].cyc <= cyc) begin
                ev = (lane_q[r][0].cyc == cyc);
                if (ev) ed = lane_q[r][0].val;
                void'(lane_q[r].pop_front());
            end
            chk($sformatf("pe_valid[%0d]", r), 32'(pe_valid[r]), 32'(ev));
            chk($sformatf("pe_val[%0d]", r), 32'(pe_val[r*DW +: DW]), 32'(ed));
        end
        wl = 1'b0;
        if (w_q.size() > 0 && w_q[0].cyc <= cyc) begin
            wl = (w_q[0].cyc == cyc);
            if (wl) last_w = w_q[0].data;
            void'(w_q.pop_front());
        end
        chk("pe_load", 32'(pe_load), 32'(wl));
        chk("pe_weight", 32'(pe_weight), 32'(last_w));
        ev = 1'b0;
        if (done_q.size() > 0 && done_q[0] <= cyc) begin
            ev = (done_q[0] == cyc);
            void'(done_q.pop_front());
        end
        chk("done", 32'(done), 32'(ev));
        chk("busy", 32'(busy), 32'(cyc >= busy_from && cyc <= busy_until));
    end

    task automatic start_job();
        start = 1'b1;
        @(negedge clk);
        busy_from  = cyc + 1;
        busy_until = BIG;
        vec_model  = 0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("w_ready_after_start", 32'(w_ready), 32'd1);
        chk("in_ready_in_load", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic send_weight(input logic [VW-1:0] d);
        int budget;
        budget  = 20;
        w_valid = 1'b1;
        w_data  = d;
        forever begin
            @(negedge clk);
            if (w_ready) begin
                w_q.push_back('{cyc: cyc + 1, data: d});
                break;
            end
            budget--;
            if (budget == 0) begin
                chk("w_ready_timeout", 32'(w_ready), 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        w_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [VW-1:0] d, input logic last);
        int        budget;
        lane_exp_t e;
        budget   = 20;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                for (int r = 0; r < int'(N); r++) begin
                    e.cyc = cyc + 1 + r;
                    e.val = d[r*DW +: DW];
                    lane_q[r].push_back(e);
                end
                vec_model++;
                if (last) begin
                    done_q.push_back(cyc + int'(N));
                    busy_until = cyc + int'(N);
                end
                break;
            end
            budget--;
            if (budget == 0) begin
                chk("in_ready_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 40;
        forever begin
            @(negedge clk);
            if (!busy) break;
            budget--;
            if (budget == 0) begin
                chk("busy_timeout", 32'(busy), 32'd0);
                break;
            end
        end
`ifdef FEEDER_STATS_EN
        chk("vec_count", 32'(vec_count), 32'(vec_model));
`endif
        @(posedge clk); #1;
    endtask

    task automatic load_weights(input bit gaps);
        logic [VW-1:0] d;
        for (int i = 0; i < int'(N); i++) begin
            if (gaps && ($urandom % 3) == 0) idle_cycle();
            d = VW'($urandom);
            send_weight(d);
        end
    endtask

    task automatic run_random_job(input int nvec);
        logic [VW-1:0] d;
        start_job();
        load_weights(1'b1);
        for (int v = 0; v < nvec; v++) begin
            if (($urandom % 3) == 0) idle_cycle();
            d = VW'($urandom);
            send_vec(d, v == nvec - 1);
        end
        wait_idle();
    endtask

    initial begin
        logic [VW-1:0] wrows [4];
        wrows[0] = 16'h1234; wrows[1] = 16'h5678; wrows[2] = 16'h9ABC; wrows[3] = 16'hDEF0;

        // Initial reset: all outputs at reset values.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_w_ready", 32'(w_ready), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_pe_val", 32'(pe_val), 32'd0);
`ifdef FEEDER_STATS_EN
        chk("rst_vec_count", 32'(vec_count), 32'd0);
`endif
        @(posedge clk); #1;

        // Directed weight load, then a single-vector skew job.
        start_job();
        for (int i = 0; i < 4; i++) send_weight(wrows[i]);
        @(negedge clk);
        chk("stream_in_ready", 32'(in_ready), 32'd1);
        chk("stream_w_ready", 32'(w_ready), 32'd0);
        @(posedge clk); #1;
        send_vec(16'h4321, 1'b1);
        wait_idle();

        // Ignored start/w_valid in STREAM, then bubble job.
        start_job();
        load_weights(1'b0);
        start   = 1'b1;
        w_valid = 1'b1;
        w_data  = 16'hA5A5;
        @(negedge clk);
        chk("w_ready_in_stream", 32'(w_ready), 32'd0);
        chk("in_ready_in_stream", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        start   = 1'b0;
        w_valid = 1'b0;
        send_vec(16'h1111, 1'b0);
        idle_cycle();
        send_vec(16'h2222, 1'b1);
        wait_idle();

        // Negative values pass bit-exact.
        start_job();
        load_weights(1'b0);
        send_vec(16'h8F0F, 1'b1);
        wait_idle();

        // Randomised jobs.
        for (int j = 0; j < 6; j++) run_random_job(1 + int'($urandom % 8));

        // Reset in the middle of STREAM.
        start_job();
        load_weights(1'b0);
        send_vec(16'h5A5A, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h7F31;
        reset    = 1'b1;
        reset_model();
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_pe_valid", 32'(pe_valid), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (8) idle_cycle();

        // Recovery job after reset.
        run_random_job(5);
        repeat (4) idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
